seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 106 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with tear-free loading.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits 3..1.
module seg7_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD_VALID,
    input  logic [15:0] LOAD_DATA,
    output logic        LOAD_READY,
    output logic [3:0]  DIG_NUM,
    output logic [3:0]  AN,
    output logic        FRAME_TICK,
    output logic        ERR
);

    localparam logic [15:0] CNT_MAX = 16'(PRESCALE - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [15:0] disp;
    logic [15:0] pend;
    logic        pend_full;
    logic        tick;
    logic        frame;
    logic        xfer;
    logic        load_bad;
    logic [3:0]  nib [4];
    logic [3:0]  blank;
    logic [3:0]  cur_num;
    logic [3:0]  an_next;

    assign tick       = (cnt == CNT_MAX);
    assign frame      = tick && (idx == 2'd3);
    assign LOAD_READY = !pend_full && !RESET;
    assign xfer       = LOAD_VALID && LOAD_READY;
    assign FRAME_TICK = frame;

    // Any incoming nibble above 9 marks the word as non-BCD.
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (LOAD_DATA[4*i +: 4] > 4'd9) load_bad = 1'b1;
        end
    end

    // Per-digit blanking and the next registered digit/anode values.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nib[i]   = disp[4*i +: 4];
            blank[i] = (nib[i] > 4'd9);
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (disp[15:12] == 4'd0) blank[3] = 1'b1;
        if (disp[15:8] == 8'd0)  blank[2] = 1'b1;
        if (disp[15:4] == 12'd0) blank[1] = 1'b1;
`endif
        cur_num = nib[idx];
        an_next = blank[idx] ? 4'hF : ~(4'b0001 << idx);
    end

    // Prescale counter and digit index advance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= 16'd0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= 16'd0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Pending slot, display register and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend      <= 16'h0000;
            pend_full <= 1'b0;
            disp      <= 16'h0000;
            ERR       <= 1'b0;
        end else begin
            if (frame && pend_full) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end
            if (xfer) begin
                pend      <= LOAD_DATA;
                pend_full <= 1'b1;
                if (load_bad) ERR <= 1'b1;
            end
        end
    end

    // Registered digit value and active-low anode drive.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DIG_NUM <= 4'h0;
            AN      <= 4'hF;
        end else begin
            DIG_NUM <= cur_num;
            AN      <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with PRESCALE=4.
// Expected digit slots are queued per frame and compared every cycle.
module tb_seg7_scan_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        LOAD_VALID = 1'b0;
    logic [15:0] LOAD_DATA = 16'h0000;
    logic        LOAD_READY;
    logic [3:0]  DIG_NUM;
    logic [3:0]  AN;
    logic        FRAME_TICK;
    logic        ERR;

    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    bit          done = 1'b0;
    logic [7:0]  cur = 8'hF0;
    logic [7:0]  sb [$];

    seg7_scan_ctrl #(.PRESCALE(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_DATA(LOAD_DATA),
        .LOAD_READY(LOAD_READY),
        .DIG_NUM(DIG_NUM),
        .AN(AN),
        .FRAME_TICK(FRAME_TICK),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Cycles since reset release; 1 is the first non-reset edge.
    always @(posedge CLK) n <= RESET ? 0 : n + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    task automatic push_frame(input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] d;
            logic [3:0] a;
            logic       bl;
            d  = w[4*k +: 4];
            bl = (d > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && (w >> (4 * k)) == 16'd0) bl = 1'b1;
`endif
            a = 4'b0001 << k;
            a = bl ? 4'hF : ~a;
            sb.push_back({a, d});
        end
    endtask

    task automatic wait_to(input int t);
        while (n < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Output monitor: pop one slot expectation per digit period.
    always @(negedge CLK) begin
        if (!RESET && !done && n >= 1) begin
            if (n % 4 == 1) begin
                check("sb_avail", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) cur = sb.pop_front();
            end
            check("an", 32'(AN), 32'(cur[7:4]));
            check("dig_num", 32'(DIG_NUM), 32'(cur[3:0]));
            check("frame_tick", 32'(FRAME_TICK), 32'(n % 16 == 15));
            check("an_onehot", 32'($countones(~AN) <= 1), 1);
        end
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_an", 32'(AN), 32'hF);
        check("rst_dig", 32'(DIG_NUM), 0);
        check("rst_ready", 32'(LOAD_READY), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_tick", 32'(FRAME_TICK), 0);
        push_frame(16'h0000);
        push_frame(16'h0000);
        RESET = 1'b0;

        wait_to(20);
        check("ready_idle", 32'(LOAD_READY), 1);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h1234;
        push_frame(16'h1234);
        step();
        LOAD_VALID = 1'b0;
        check("ready_pend", 32'(LOAD_READY), 0);
        wait_to(30);
        check("ready_hold", 32'(LOAD_READY), 0);
        wait_to(31);
        check("tick_31", 32'(FRAME_TICK), 1);
        check("ready_at_tick", 32'(LOAD_READY), 0);
        wait_to(32);
        check("ready_after_tick", 32'(LOAD_READY), 1);

        wait_to(33);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h1111;
        push_frame(16'h1111);
        step();
        LOAD_DATA = 16'h2222;
        check("b2b_stall", 32'(LOAD_READY), 0);
        while (!LOAD_READY && n < 80) step();
        check("b2b_accept_n", 32'(n), 48);
        push_frame(16'h2222);
        step();
        LOAD_VALID = 1'b0;
        check("b2b_ready", 32'(LOAD_READY), 0);

        wait_to(66);
        check("err_before", 32'(ERR), 0);
        check("ready_err", 32'(LOAD_READY), 1);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h12A4;
        push_frame(16'h12A4);
        step();
        LOAD_VALID = 1'b0;
        check("err_set", 32'(ERR), 1);

        wait_to(82);
        check("ready_0070", 32'(LOAD_READY), 1);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h0070;
        push_frame(16'h0070);
        step();
        LOAD_VALID = 1'b0;
        wait_to(90);
        check("err_sticky", 32'(ERR), 1);

        wait_to(100);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h5678;
        step();
        LOAD_VALID = 1'b0;
        check("pend_full", 32'(LOAD_READY), 0);
        wait_to(103);
        RESET = 1'b1;
        step();
        check("rst2_an", 32'(AN), 32'hF);
        check("rst2_dig", 32'(DIG_NUM), 0);
        check("rst2_err", 32'(ERR), 0);
        check("rst2_ready", 32'(LOAD_READY), 0);
        check("rst2_tick", 32'(FRAME_TICK), 0);
        sb.delete();
        push_frame(16'h0000);
        push_frame(16'h0000);
        RESET = 1'b0;
        wait_to(1);
        check("rst2_ready_up", 32'(LOAD_READY), 1);
        wait_to(20);
        check("rst2_err_low", 32'(ERR), 0);
        wait_to(32);
        done = 1'b1;
        check("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
